// File: rtl/execute_pipe_if.sv
// rtl/execute_pipe_if.sv - operand/result handshake bundle for execute_pipe
interface execute_pipe_if #(
  parameter int N       = 32,
  parameter int ALU_NUM = 8
);
  logic                         in_valid;
  logic                         in_ready;
  logic [ALU_NUM-1:0]           enable_alu;
  logic [2:0]                   instr;
  logic [ALU_NUM-1:0][N-1:0]    dataA;
  logic [ALU_NUM-1:0][N-1:0]    dataB;
  logic                         out_valid;
  logic                         out_ready;
  logic [ALU_NUM-1:0][N-1:0]    data_out;
  logic [ALU_NUM-1:0]           ovf;
  logic                         zero;
  logic                         any_zero;
  logic [ALU_NUM-1:0]           lane_mask;

  modport master (
    output in_valid, enable_alu, instr, dataA, dataB, out_ready,
    input  in_ready, out_valid, data_out, ovf, zero, any_zero, lane_mask
  );

  modport slave (
    input  in_valid, enable_alu, instr, dataA, dataB, out_ready,
    output in_ready, out_valid, data_out, ovf, zero, any_zero, lane_mask
  );
endinterface

// File: rtl/execute_pipe.sv
// rtl/execute_pipe.sv - multi-lane fixed-point execute stage with valid/ready pipeline
module execute_pipe #(
  parameter int N       = 32,
  parameter int Q       = 16,
  parameter int ALU_NUM = 8,
  parameter int LAT     = 2,
  parameter int SAT     = 1
) (
  input logic           clk,
  input logic           rstn,
  execute_pipe_if.slave bus
);

  localparam logic [N-1:0] MAX_V = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_V = {1'b1, {(N-1){1'b0}}};

  // Returns {ovf, result} for one lane.
  function automatic logic [N:0] lane_op(input logic [2:0] op,
                                         input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    logic signed [N:0]     s;
    logic signed [2*N-1:0] ae;
    logic signed [2*N-1:0] be;
    logic signed [2*N-1:0] p;
    logic [N-1:0]          r;
    logic                  ov;
    s  = '0;
    ae = {{N{a[N-1]}}, a};
    be = {{N{b[N-1]}}, b};
    p  = '0;
    r  = '0;
    ov = 1'b0;
    case (op)
      3'd0, 3'd1: begin
        s  = (op == 3'd0) ? ($signed({a[N-1], a}) + $signed({b[N-1], b}))
                          : ($signed({a[N-1], a}) - $signed({b[N-1], b}));
        ov = s[N] ^ s[N-1];
        r  = s[N-1:0];
        if (ov && SAT != 0) r = s[N] ? MIN_V : MAX_V;
      end
      3'd2: begin
        // Arithmetic shift floors toward -inf; result fits only if the top N+1 bits agree.
        p  = (ae * be) >>> Q;
        ov = (p[2*N-1:N-1] != {(N+1){p[N-1]}});
        r  = p[N-1:0];
        if (ov && SAT != 0) r = p[2*N-1] ? MIN_V : MAX_V;
      end
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = ($signed(a) < $signed(b)) ? a : b;
      default: r = ($signed(a) > $signed(b)) ? a : b;
    endcase
    return {ov, r};
  endfunction

  logic [ALU_NUM-1:0][N-1:0] nx_data;
  logic [ALU_NUM-1:0]        nx_ovf;
  logic                      nx_zero;
  logic                      nx_any;

  always_comb begin
    nx_data = '0;
    nx_ovf  = '0;
    nx_zero = 1'b1;
    nx_any  = 1'b0;
    for (int i = 0; i < ALU_NUM; i++) begin
      if (bus.enable_alu[i]) begin
        {nx_ovf[i], nx_data[i]} = lane_op(bus.instr, bus.dataA[i], bus.dataB[i]);
        if (nx_data[i] == '0) nx_any = 1'b1;
        else                  nx_zero = 1'b0;
      end
    end
  end

  logic [LAT-1:0]            st_valid;
  logic [LAT-1:0]            st_zero;
  logic [LAT-1:0]            st_any;
  logic [ALU_NUM-1:0]        st_mask [LAT];
  logic [ALU_NUM-1:0]        st_ovf  [LAT];
  logic [ALU_NUM-1:0][N-1:0] st_data [LAT];
  logic                      advance;

  // The whole pipe moves as one; a full output slot that is not taken freezes everything.
  assign advance      = !st_valid[LAT-1] || bus.out_ready;
  assign bus.in_ready = advance;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_valid <= '0;
      st_zero  <= '0;
      st_any   <= '0;
      for (int i = 0; i < LAT; i++) begin
        st_mask[i] <= '0;
        st_ovf[i]  <= '0;
        st_data[i] <= '0;
      end
    end else if (advance) begin
      st_valid[0] <= bus.in_valid;
      st_zero[0]  <= nx_zero;
      st_any[0]   <= nx_any;
      st_mask[0]  <= bus.enable_alu;
      st_ovf[0]   <= nx_ovf;
      st_data[0]  <= nx_data;
      for (int i = 1; i < LAT; i++) begin
        st_valid[i] <= st_valid[i-1];
        st_zero[i]  <= st_zero[i-1];
        st_any[i]   <= st_any[i-1];
        st_mask[i]  <= st_mask[i-1];
        st_ovf[i]   <= st_ovf[i-1];
        st_data[i]  <= st_data[i-1];
      end
    end
  end

  assign bus.out_valid = st_valid[LAT-1];
  assign bus.data_out  = st_data[LAT-1];
  assign bus.ovf       = st_ovf[LAT-1];
  assign bus.zero      = st_zero[LAT-1];
  assign bus.any_zero  = st_any[LAT-1];
  assign bus.lane_mask = st_mask[LAT-1];

endmodule

// File: tb/tb_execute_pipe.sv
// tb/tb_execute_pipe.sv - self-checking bench for execute_pipe (SAT=1 and SAT=0 side by side)
module tb_execute_pipe;
  localparam int N       = 32;
  localparam int Q       = 16;
  localparam int ALU_NUM = 8;
  localparam int LAT     = 2;

  logic clk = 1'b0;
  logic rstn;
  logic iv;
  logic ordy;
  logic [ALU_NUM-1:0]        mask;
  logic [2:0]                op;
  logic [ALU_NUM-1:0][N-1:0] va;
  logic [ALU_NUM-1:0][N-1:0] vb;

  always #5 clk = ~clk;

  execute_pipe_if #(.N(N), .ALU_NUM(ALU_NUM)) bus1 ();
  execute_pipe_if #(.N(N), .ALU_NUM(ALU_NUM)) bus0 ();

  assign bus1.in_valid = iv;   assign bus0.in_valid = iv;
  assign bus1.enable_alu = mask; assign bus0.enable_alu = mask;
  assign bus1.instr = op;      assign bus0.instr = op;
  assign bus1.dataA = va;      assign bus0.dataA = va;
  assign bus1.dataB = vb;      assign bus0.dataB = vb;
  assign bus1.out_ready = ordy; assign bus0.out_ready = ordy;

  execute_pipe #(.N(N), .Q(Q), .ALU_NUM(ALU_NUM), .LAT(LAT), .SAT(1)) u1 (.clk(clk), .rstn(rstn), .bus(bus1));
  execute_pipe #(.N(N), .Q(Q), .ALU_NUM(ALU_NUM), .LAT(LAT), .SAT(0)) u0 (.clk(clk), .rstn(rstn), .bus(bus0));

  typedef struct {
    logic [ALU_NUM-1:0][N-1:0] d1;
    logic [ALU_NUM-1:0][N-1:0] d0;
    logic [ALU_NUM-1:0]        o1;
    logic [ALU_NUM-1:0]        o0;
    logic [ALU_NUM-1:0]        m;
    logic                      z1, a1, z0, a0;
    int                        acc;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   stepn = 0;
  int   last_lat = 0;
  bit   acc_flag;
  bit   collect = 0;
  int   res_seq[$];
  logic [ALU_NUM-1:0][N-1:0] last_d1, last_d0;
  logic [ALU_NUM-1:0]        last_o1, last_o0, last_m;
  logic                      last_z1, last_a1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Exact-value model: compute with 64-bit integers, then range-check.
  function automatic void lane_model(input logic [2:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                                     input bit sat, output logic [N-1:0] r, output logic ov);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint mx = (longint'(1) <<< (N-1)) - 1;
    longint mn = -mx - 1;
    longint e;
    ov = 1'b0;
    case (o)
      3'd0: e = sa + sb;
      3'd1: e = sa - sb;
      3'd2: e = (sa * sb) >>> Q;
      3'd3: e = sa & sb;
      3'd4: e = sa | sb;
      3'd5: e = sa ^ sb;
      3'd6: e = (sa < sb) ? sa : sb;
      default: e = (sa > sb) ? sa : sb;
    endcase
    if (o <= 3'd2 && (e > mx || e < mn)) begin
      ov = 1'b1;
      if (sat) e = (e > mx) ? mx : mn;
    end
    r = e[N-1:0];
  endfunction

  function automatic exp_t model();
    exp_t e;
    e.d1 = '0; e.d0 = '0; e.o1 = '0; e.o0 = '0; e.m = mask;
    e.z1 = 1'b1; e.a1 = 1'b0; e.z0 = 1'b1; e.a0 = 1'b0;
    e.acc = stepn;
    for (int i = 0; i < ALU_NUM; i++) begin
      if (mask[i]) begin
        lane_model(op, va[i], vb[i], 1'b1, e.d1[i], e.o1[i]);
        lane_model(op, va[i], vb[i], 1'b0, e.d0[i], e.o0[i]);
        if (e.d1[i] == 0) e.a1 = 1'b1; else e.z1 = 1'b0;
        if (e.d0[i] == 0) e.a0 = 1'b1; else e.z0 = 1'b0;
      end
    end
    return e;
  endfunction

  task automatic pop_check();
    exp_t e;
    vectors++;
    assert (q.size() > 0) else begin
      miscompares++;
      $error("FAIL unexpected_output observed=extra_bundle expected=none");
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("data_sat", bus1.data_out, e.d1);
      chk("ovf_sat", bus1.ovf, e.o1);
      chk("zero_sat", bus1.zero, e.z1);
      chk("any_zero_sat", bus1.any_zero, e.a1);
      chk("lane_mask", bus1.lane_mask, e.m);
      chk("valid_wrap", bus0.out_valid, 1'b1);
      chk("data_wrap", bus0.data_out, e.d0);
      chk("ovf_wrap", bus0.ovf, e.o0);
      chk("zero_wrap", bus0.zero, e.z0);
      chk("any_zero_wrap", bus0.any_zero, e.a0);
      last_lat = stepn - e.acc;
      last_d1 = bus1.data_out; last_d0 = bus0.data_out;
      last_o1 = bus1.ovf; last_o0 = bus0.ovf; last_m = bus1.lane_mask;
      last_z1 = bus1.zero; last_a1 = bus1.any_zero;
      if (collect) res_seq.push_back(int'(bus1.data_out[0]));
    end
  endtask

  task automatic step();
    @(negedge clk);
    acc_flag = 1'b0;
    if (rstn) begin
      if (bus1.out_valid && ordy) pop_check();
      if (iv && bus1.in_ready) begin
        q.push_back(model());
        acc_flag = 1'b1;
      end
    end else begin
      q.delete();
    end
    @(posedge clk);
    #1;
    stepn++;
  endtask

  task automatic set_all(input logic [2:0] o, input logic [ALU_NUM-1:0] m,
                         input logic [N-1:0] a, input logic [N-1:0] b);
    op = o; mask = m;
    for (int i = 0; i < ALU_NUM; i++) begin
      va[i] = a; vb[i] = b;
    end
  endtask

  task automatic drain();
    iv = 1'b0; ordy = 1'b1;
    for (int k = 0; k < 20 && q.size() > 0; k++) step();
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic send_one();
    iv = 1'b1; ordy = 1'b1;
    step();
    drain();
  endtask

  function automatic logic [N-1:0] rnd_val();
    logic [31:0] u;
    int k;
    u = $urandom;
    k = $urandom_range(0, 3);
    case (k)
      0: return u;
      1: return 32'($urandom_range(0, 200)) - 32'd100;
      2: case (u[1:0])
           2'd0: return 32'h7FFFFFFF;
           2'd1: return 32'h80000000;
           2'd2: return 32'h0;
           default: return 32'hFFFFFFFF;
         endcase
      default: return 32'($signed(u) >>> 12);
    endcase
  endfunction

  logic [ALU_NUM-1:0][N-1:0] snap;
  int sent;

  initial begin
    rstn = 1'b0; iv = 1'b0; ordy = 1'b1;
    set_all(3'd0, '0, '0, '0);
    step(); step();
    chk("rst_out_valid", bus1.out_valid, 1'b0);
    chk("rst_data_out", bus1.data_out, '0);
    chk("rst_ovf", bus1.ovf, '0);
    chk("rst_zero", bus1.zero, 1'b0);
    chk("rst_any_zero", bus1.any_zero, 1'b0);
    chk("rst_lane_mask", bus1.lane_mask, '0);
    rstn = 1'b1;

    // Q-format multiply and latency
    set_all(3'd2, 8'hFF, 32'h00018000, 32'h00020000);
    send_one();
    chk("t1_lane0", last_d1[0], 32'h00030000);
    chk("t1_lane7", last_d1[7], 32'h00030000);
    chk("t1_ovf", last_o1, 8'h00);
    chk("t1_zero", last_z1, 1'b0);
    chk("t1_latency", last_lat, LAT);

    // Saturation vs wrap
    set_all(3'd0, 8'hFF, 32'h7FFF0000, 32'h00020000);
    send_one();
    chk("t2_add_sat", last_d1[0], 32'h7FFFFFFF);
    chk("t2_add_sat_ovf", last_o1, 8'hFF);
    chk("t2_add_wrap", last_d0[0], 32'h80010000);
    chk("t2_add_wrap_ovf", last_o0, 8'hFF);
    set_all(3'd1, 8'hFF, 32'h80000000, 32'h00000001);
    send_one();
    chk("t2_sub_sat", last_d1[3], 32'h80000000);
    chk("t2_sub_sat_ovf", last_o1, 8'hFF);
    chk("t2_sub_wrap", last_d0[3], 32'h7FFFFFFF);
    chk("t2_sub_wrap_ovf", last_o0, 8'hFF);

    // Mask and zero reductions
    set_all(3'd5, 8'h0F, $urandom, 32'h0);
    vb = va;
    send_one();
    chk("t3_data", last_d1, '0);
    chk("t3_ovf", last_o1, 8'h00);
    chk("t3_zero", last_z1, 1'b1);
    chk("t3_any", last_a1, 1'b1);
    chk("t3_mask", last_m, 8'h0F);
    vb[2] = va[2] ^ 32'h1;
    send_one();
    chk("t3b_zero", last_z1, 1'b0);
    chk("t3b_any", last_a1, 1'b1);
    set_all(3'd0, 8'h00, 32'h5, 32'h7);
    send_one();
    chk("t3c_zero", last_z1, 1'b1);
    chk("t3c_any", last_a1, 1'b0);
    chk("t3c_data", last_d1, '0);

    // Backpressure mid-stream
    sent = 0; collect = 1'b1; res_seq.delete();
    for (int t = 0; t < 40 && (sent < 6 || q.size() > 0); t++) begin
      ordy = !(t >= 3 && t < 6);
      iv = (sent < 6);
      set_all(3'd0, 8'hFF, 32'(sent + 1), 32'h1);
      #1;
      if (t == 3) begin
        chk("t4_stall_valid", bus1.out_valid, 1'b1);
        snap = bus1.data_out;
      end
      if (t >= 3 && t < 6) begin
        chk("t4_in_ready_low", bus1.in_ready, 1'b0);
        chk("t4_hold", bus1.data_out, snap);
      end
      step();
      if (acc_flag) sent++;
    end
    collect = 1'b0;
    chk("t4_count", res_seq.size(), 6);
    for (int k = 0; k < res_seq.size(); k++) chk("t4_order", res_seq[k], k + 2);

    // Reset with bundles in flight
    ordy = 1'b1; iv = 1'b1;
    set_all(3'd0, 8'hFF, 32'd10, 32'd20); step();
    set_all(3'd0, 8'hFF, 32'd30, 32'd40); step();
    iv = 1'b0; rstn = 1'b0; step(); rstn = 1'b1;
    chk("t5_out_valid", bus1.out_valid, 1'b0);
    chk("t5_data", bus1.data_out, '0);
    chk("t5_ovf", bus1.ovf, '0);
    chk("t5_zero", bus1.zero, 1'b0);
    chk("t5_any", bus1.any_zero, 1'b0);
    chk("t5_mask", bus1.lane_mask, '0);
    for (int k = 0; k < 6; k++) begin
      chk("t5_no_emerge", bus1.out_valid, 1'b0);
      step();
    end

    // MIN/MAX and signed multiply corners
    set_all(3'd6, 8'hFF, 32'hFFFFFFFD, 32'd5); send_one();
    chk("t6_min", last_d1[1], 32'hFFFFFFFD);
    set_all(3'd7, 8'hFF, 32'hFFFFFFFD, 32'd5); send_one();
    chk("t6_max", last_d1[1], 32'd5);
    set_all(3'd2, 8'hFF, 32'hFFFF8000, 32'h1); send_one();
    chk("t6_mul_floor", last_d1[0], 32'hFFFFFFFF);
    chk("t6_mul_floor_ovf", last_o1, 8'h00);
    set_all(3'd2, 8'hFF, 32'h7FFF0000, 32'h00020000); send_one();
    chk("t6_mul_sat", last_d1[0], 32'h7FFFFFFF);
    chk("t6_mul_sat_ovf", last_o1, 8'hFF);

    // Randomized traffic with random stalls
    for (int t = 0; t < 400; t++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      op   = 3'($urandom_range(0, 7));
      mask = 8'($urandom);
      for (int i = 0; i < ALU_NUM; i++) begin
        va[i] = rnd_val();
        vb[i] = ($urandom_range(0, 7) == 0) ? va[i] : rnd_val();
      end
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/execute_pipe.md
Name: execute_pipe

Overview:
- Parametrised successor to the lane-array execute stage: ALU_NUM signed fixed-point (N bits, Q fractional) lanes driven by one shared opcode and a per-lane enable mask.
- Adds a valid/ready handshake on both sides, a configurable pipeline depth LAT, and optional saturating arithmetic with per-lane overflow flags.
- Adds all-lane and any-lane zero reductions, registered with the data.
- Sits between operand fetch and writeback in the finder datapath.

Parameters:
N, 32, lane data width in bits (signed two's complement)
Q, 16, fractional bits of the fixed-point format (0 <= Q < N)
ALU_NUM, 8, number of parallel lanes
LAT, 2, pipeline depth in cycles from input accept to output valid (1..4)
SAT, 1, 1 = ADD/SUB/MUL saturate to the N-bit range; 0 = wrap

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
in_valid  in  1  operand bundle valid
in_ready  out  1  stage can accept a bundle this cycle
enable_alu  in  ALU_NUM  per-lane enable mask
instr  in  3  opcode, shared by all lanes
dataA  in  ALU_NUM x N  signed operand A per lane
dataB  in  ALU_NUM x N  signed operand B per lane
out_valid  out  1  result bundle valid
out_ready  in  1  downstream accepts the result
data_out  out  ALU_NUM x N  signed per-lane result; 0 for disabled lanes
ovf  out  ALU_NUM  per-lane overflow/saturation flag; 0 for disabled lanes
zero  out  1  every enabled lane's result == 0 (1 if mask is all zero)
any_zero  out  1  at least one enabled lane's result == 0
lane_mask  out  ALU_NUM  enable_alu captured with this bundle

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-low on rstn.
- Reset state (rstn low at a rising edge): all stage valid bits, data_out, ovf, zero, any_zero and lane_mask are cleared to 0.
- Reset mid-operation discards every in-flight bundle; out_valid is 0 in the cycle after reset.
- Opcodes, per lane, on the captured A and B:
  - 0 ADD: A+B.
  - 1 SUB: A-B.
  - 2 MUL: Q-format multiply. Full 2N-bit signed product, arithmetic shift right by Q (truncation toward -inf), then range-check to N bits.
  - 3 AND, 4 OR, 5 XOR: bitwise.
  - 6 MIN, 7 MAX: signed compare.
- Overflow and saturation:
  - ADD/SUB overflow is computed at N+1 bits.
  - If the exact result is outside [-2^(N-1), 2^(N-1)-1], ovf=1.
  - SAT=1: result clamps to 0x7F..F or 0x80..0.
  - SAT=0: result keeps the low N bits.
  - Opcodes 3-7 always give ovf=0.
- Pipeline structure:
  - LAT register stages, each holding a valid bit, mask, per-lane results, ovf and the two zero flags.
  - Arithmetic and reductions are computed combinationally from the inputs and registered into stage 1. Later stages are pure delay.
- Stall rule: advance = !out_valid | out_ready. The whole pipeline shifts when advance=1 and holds every stage when advance=0.
- Input handshake:
  - in_ready = advance, combinational, with no dependence on in_valid.
  - A bundle is accepted when in_valid & in_ready.
  - If advance=1 and in_valid=0, a bubble (valid=0) enters stage 1.
- Output handshake:
  - out_valid = valid bit of stage LAT.
  - A transfer occurs when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, all outputs hold stable.
- Latency and throughput:
  - With out_ready held high, a bundle accepted at edge k appears with out_valid=1 after edge k+LAT-1, i.e. LAT cycles after acceptance.
  - Throughput is 1 bundle per cycle.
  - Maximum occupancy is LAT bundles; no bundle is ever dropped or duplicated.
- Simultaneous events: accept on the input and transfer on the output in the same cycle is legal and required at full rate.
- Disabled lanes: data_out=0 and ovf=0; these lanes are excluded from both zero reductions.
- Empty mask: enable_alu=0 in a valid bundle is legal and gives zero=1, any_zero=0, all data_out=0.
- Output gating: outputs while out_valid=0 are don't-care apart from reset values.

Test Plan:
1. Defaults, single bundle, mask 0xFF, MUL: A=0x00018000 (1.5), B=0x00020000 (2.0), out_ready=1 -> data_out=0x00030000 on all lanes, ovf=0, zero=0, out_valid exactly 2 cycles after accept.
2. SAT=1 ADD: A=0x7FFF0000, B=0x00020000 -> 0x7FFFFFFF, ovf=1. SUB with A=0x80000000, B=1 -> 0x80000000, ovf=1. Repeat with SAT=0 -> 0x80010000 and 0x7FFFFFFF, ovf=1.
3. Mask and zero reductions:
   - Mask 0x0F, XOR with A=B -> lanes 0-3 give 0, zero=1, any_zero=1; lanes 4-7 give 0 with ovf=0; lane_mask=0x0F.
   - One enabled lane nonzero -> zero=0, any_zero=1.
   - Mask 0x00 -> zero=1, any_zero=0.
4. Backpressure: stream 6 back-to-back bundles (ADD, A=i, B=1) and hold out_ready=0 for 3 cycles mid-stream -> in_ready drops the same cycle, outputs hold stable, results 1..6 appear in order with none lost or duplicated.
5. Reset mid-operation: 2 bundles in flight, pull rstn low for 1 cycle -> next cycle out_valid=0 and all outputs 0; neither pre-reset bundle ever emerges.
6. MIN/MAX and signed MUL truncation: MIN(-3,5)=-3, MAX(-3,5)=5. MUL with A=0xFFFF8000 (-0.5), B=0x00000001 -> 0xFFFFFFFF (floor), ovf=0. MUL 0x7FFF0000 x 0x00020000 with SAT=1 -> 0x7FFFFFFF, ovf=1.
